// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit seven-segment scan driver with per-slot blanking and a double-buffered value.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses digits above the most significant nonzero nibble.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  digit_en,
  output logic [6:0]  lcd,
  output logic [3:0]  digits,
  output logic [1:0]  scan_idx,
  output logic        frame_done,
  output logic        state_dbg
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_t;

  localparam state_t ST_INIT = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   shadow, pending;
  logic          pend_flag;
  logic          wrap, boundary;
  logic [3:0]    nib;
  logic          show;
  logic [6:0]    lcd_nxt;
  logic [3:0]    digits_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msn;
  always_comb begin
    msn = 2'd0;
    if (shadow[15:12] != 4'h0)     msn = 2'd3;
    else if (shadow[11:8] != 4'h0) msn = 2'd2;
    else if (shadow[7:4] != 4'h0)  msn = 2'd1;
  end
  // Digit 0 always passes since msn is never below 0.
  assign show = digit_en[scan_idx] && (scan_idx <= msn);
`else
  assign show = digit_en[scan_idx];
`endif

  assign state_dbg = (state == ST_ON);

  always_comb begin
    wrap       = (cnt == CW'(SCAN_DIV - 1));
    boundary   = wrap && (scan_idx == 2'd3);
    cnt_nxt    = wrap ? '0 : cnt + CW'(1);
    state_nxt  = (32'(cnt_nxt) < BLANK_CYCLES) ? ST_BLANK : ST_ON;
    nib        = shadow[{scan_idx, 2'b00} +: 4];
    lcd_nxt    = 7'h7F;
    digits_nxt = 4'hF;
    if (state == ST_ON && show) begin
      digits_nxt = ~(4'b0001 << scan_idx);
      lcd_nxt    = ~hex7(nib);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      scan_idx   <= 2'd0;
      state      <= ST_INIT;
      lcd        <= 7'h7F;
      digits     <= 4'hF;
      frame_done <= 1'b0;
      shadow     <= 16'h0;
      pending    <= 16'h0;
      pend_flag  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      state      <= state_nxt;
      lcd        <= lcd_nxt;
      digits     <= digits_nxt;
      frame_done <= boundary;
      if (wrap) scan_idx <= scan_idx + 2'd1;
      // A load landing on the frame boundary bypasses the pending buffer.
      if (boundary) begin
        if (load)           shadow <= value;
        else if (pend_flag) shadow <= pending;
        pend_flag <= 1'b0;
      end else if (load) begin
        pending   <= value;
        pend_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2, plus a BLANK_CYCLES=0 copy).
// Honours LEADING_ZERO_BLANK_EN when computing expected displays.
module tb_seg_scan_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [6:0]  lcd, lcd0;
  logic [3:0]  digits, digits0;
  logic [1:0]  scan_idx, scan_idx0;
  logic        frame_done, frame_done0;
  logic        state_dbg, state_dbg0;

  int vectors = 0;
  int errors  = 0;
  int t       = 0;

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load), .digit_en(digit_en),
    .lcd(lcd), .digits(digits), .scan_idx(scan_idx), .frame_done(frame_done),
    .state_dbg(state_dbg));

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .value(value), .load(load), .digit_en(digit_en),
    .lcd(lcd0), .digits(digits0), .scan_idx(scan_idx0), .frame_done(frame_done0),
    .state_dbg(state_dbg0));

  always #5 clock = ~clock;

  // After step() returns, outputs reflect cycle t-1 (cnt=(t-1)%8, idx=((t-1)/8)%4).
  task automatic step();
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic go_to(input int target);
    while (t < target) step();
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] exp_d, input logic [6:0] exp_l);
    chk({tag, "_digits"}, {28'h0, digits}, {28'h0, exp_d});
    chk({tag, "_lcd"}, {25'h0, lcd}, {25'h0, exp_l});
  endtask

  initial begin
    int c0, c1, c2, c3, lit, lit0, fd_cnt, last_fd, waited;
    reset = 1'b1; value = 16'h0; load = 1'b0; digit_en = 4'hF;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_digits", {28'h0, digits}, 32'hF);
    chk("rst_lcd", {25'h0, lcd}, 32'h7F);
    chk("rst_idx", {30'h0, scan_idx}, 32'h0);
    chk("rst_fd", {31'h0, frame_done}, 32'h0);
    chk("rst_state", {31'h0, state_dbg}, 32'h0);
    chk("rst_state0", {31'h0, state_dbg0}, 32'h1);
    reset = 1'b0;
    t = 0;

    // First frame shows shadow=0; then 16'h1234 from the next frame.
    step();
    chk_disp("blank_c0", 4'hF, 7'h7F);
    go_to(3);
    chk_disp("zero_idx0", 4'b1110, 7'h40);
    pulse_load(16'h1234);
    go_to(35);
    chk_disp("h1234_idx0", 4'b1110, 7'b0011001);
    chk("h1234_scan0", {30'h0, scan_idx}, 32'h0);
    go_to(43);
    chk_disp("h1234_idx1", 4'b1101, 7'b0110000);
    go_to(51);
    chk_disp("h1234_idx2", 4'b1011, 7'b0100100);
    go_to(59);
    chk_disp("h1234_idx3", 4'b0111, 7'b1111001);
    chk("h1234_scan3", {30'h0, scan_idx}, 32'h3);

    // Slot shape: 2 blank + 6 lit, and all 8 lit with no blanking.
    lit = 0; lit0 = 0;
    go_to(64);
    for (int k = 0; k < 8; k++) begin
      step();
      if (digits == 4'b1110) lit++;
      if (digits0 == 4'b1110) lit0++;
      if (k == 1) chk("slot_blank1", {28'h0, digits}, 32'hF);
    end
    chk("slot_lit6", lit, 6);
    chk("slot_lit8_noblank", lit0, 8);

    // Digit enable mask 0101 over three frames.
    go_to(96);
    digit_en = 4'b0101;
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int k = 0; k < 96; k++) begin
      step();
      if (!digits[0]) c0++;
      if (!digits[1]) c1++;
      if (!digits[2]) c2++;
      if (!digits[3]) c3++;
    end
    digit_en = 4'hF;
    chk("en_d0", c0, 18);
    chk("en_d1", c1, 0);
    chk("en_d2", c2, 18);
    chk("en_d3", c3, 0);

    // frame_done over 128 free-running cycles.
    fd_cnt = 0; last_fd = 0;
    for (int k = 0; k < 128; k++) begin
      step();
      if (frame_done) begin
        fd_cnt++;
        if (last_fd != 0) chk("fd_spacing", t - last_fd, 32);
        else chk("fd_first", t, 224);
        last_fd = t;
      end
    end
    chk("fd_count", fd_cnt, 4);

    // Mid-frame load must not disturb the current frame.
    go_to(330);
    pulse_load(16'hFFFF);
    go_to(340);
    chk_disp("midload_idx2", 4'b1011, 7'b0100100);
    go_to(350);
    chk_disp("midload_idx3", 4'b0111, 7'b1111001);
    go_to(355);
    chk_disp("hffff_idx0", 4'b1110, 7'h0E);
    go_to(379);
    chk_disp("hffff_idx3", 4'b0111, 7'h0E);

    // Asynchronous reset in the middle of the idx-2 lit slot.
    go_to(404);
    chk_disp("pre_rst_idx2", 4'b1011, 7'h0E);
    #3;
    reset = 1'b1;
    #1;
    chk_disp("async_rst", 4'hF, 7'h7F);
    chk("async_rst_idx", {30'h0, scan_idx}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    t = 0;
    waited = 0;
    while (digits == 4'hF && waited < 20) begin
      step();
      waited++;
    end
    chk("post_rst_first_lit_t", t, 3);
    chk_disp("post_rst_first_lit", 4'b1110, 7'h40);

    // Repeated loads: last wins. Then a load coinciding with the boundary.
    go_to(5);
    pulse_load(16'h5555);
    go_to(10);
    pulse_load(16'h0042);
    go_to(35);
    chk_disp("h0042_idx0", 4'b1110, 7'h24);
    go_to(43);
    chk_disp("h0042_idx1", 4'b1101, 7'h19);
    go_to(51);
`ifdef LEADING_ZERO_BLANK_EN
    chk_disp("h0042_idx2", 4'hF, 7'h7F);
`else
    chk_disp("h0042_idx2", 4'b1011, 7'h40);
`endif
    go_to(59);
`ifdef LEADING_ZERO_BLANK_EN
    chk_disp("h0042_idx3", 4'hF, 7'h7F);
`else
    chk_disp("h0042_idx3", 4'b0111, 7'h40);
`endif
    go_to(63);
    pulse_load(16'h0000);
    go_to(67);
    chk_disp("h0000_idx0", 4'b1110, 7'b1000000);
    go_to(75);
`ifdef LEADING_ZERO_BLANK_EN
    chk_disp("h0000_idx1", 4'hF, 7'h7F);
`else
    chk_disp("h0000_idx1", 4'b1101, 7'h40);
`endif
    go_to(91);
`ifdef LEADING_ZERO_BLANK_EN
    chk_disp("h0000_idx3", 4'hF, 7'h7F);
`else
    chk_disp("h0000_idx3", 4'b0111, 7'h40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
